// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch buffer.
// Entry layout is {pc, instr}; pc is the byte address the word was fetched from.
package ifetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam int          IFETCH_DEPTH_DEF    = 4;
   localparam logic [31:0] IFETCH_RESET_PC_DEF = 32'h0000_0000;

   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of fetch entries. flush wins over push/pop; an empty FIFO
// presents all-zero read data so the top's outputs are zero when idle.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = IFETCH_DEPTH_DEF,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  fetch_entry_t  wdata,
   output fetch_entry_t  rdata,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: it is only observed through rdata when count != 0.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: drives the ROM address from fetch_pc, queues {pc, instr} pairs and
// hands them to decode. Optional zero-latency bypass: define IFETCH_BYPASS_EN.
module instruction_fetch_buffer
   import ifetch_pkg::*;
#(
   parameter int          SIZE     = 64,
   parameter int          ADDR_W   = $clog2(SIZE),
   parameter int          DEPTH    = IFETCH_DEPTH_DEF,
   parameter logic [31:0] RESET_PC = IFETCH_RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   fetch_entry_t  wentry;
   logic          fifo_valid;
   logic          bypass_active;
   logic          pop;
   logic          push;
   logic          fifo_push;
   logic          fifo_pop;

   assign imem_addr  = fetch_pc[ADDR_W+1:2];
   assign fifo_valid = (count != '0);
   assign wentry     = '{pc: fetch_pc, instr: imem_rdata};

`ifdef IFETCH_BYPASS_EN
   // Reset is gated in so out_valid reads 0 while rst is held.
   assign bypass_active = !fifo_valid && !redirect_valid && !rst;
`else
   assign bypass_active = 1'b0;
`endif

   // Handshake: an entry transfers on a cycle where out_valid & out_ready; while
   // out_valid & !out_ready, out_* hold and out_valid stays high unless a
   // redirect or reset intervenes.
   always_comb begin
      out_valid = fifo_valid;
      out_instr = head.instr;
      out_pc    = head.pc;
      if (bypass_active) begin
         out_valid = 1'b1;
         out_instr = imem_rdata;
         out_pc    = fetch_pc;
      end
   end

   assign pop  = out_valid && out_ready;
   assign push = !redirect_valid && ((count < CW'(DEPTH)) || pop);

   // A bypassed word consumed this cycle never lands in the FIFO.
   assign fifo_push = push && !(bypass_active && pop);
   assign fifo_pop  = pop && fifo_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~32'h3;
      end else if (push) begin
         fetch_pc <= next_pc(fetch_pc);
      end
   end

   ifetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (wentry),
      .rdata (head),
      .count (count)
   );

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Bench for instruction_fetch_buffer: ROM model, queue-based reference model,
// directed scenarios plus randomized ready/redirect traffic.
module tb_instruction_fetch_buffer;

   localparam int SIZE   = 64;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 4;
`ifdef IFETCH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              redirect_valid = 1'b0;
   logic [31:0]       redirect_pc = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_instr;
   logic [31:0]       out_pc;

   logic [31:0] rom [SIZE];
   logic [31:0] init_words [4];

   // Reference model state
   logic [63:0] exp_q [$];
   logic [31:0] m_pc;
   logic        e_valid;
   logic [31:0] e_pc;
   logic [31:0] e_instr;
   logic [ADDR_W-1:0] e_addr;

   int n_checks = 0;
   int n_pass   = 0;

   // Clock and reset
   always #5 clk = ~clk;

   assign imem_rdata = rom[imem_addr];

   instruction_fetch_buffer #(
      .SIZE     (SIZE),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   function automatic logic [ADDR_W-1:0] rom_index(input logic [31:0] pc);
      return ADDR_W'((pc / 32'd4) % SIZE);
   endfunction

   function automatic string obs_str();
      return $sformatf("got v=%b pc=%h ins=%h addr=%0d", out_valid, out_pc, out_instr, imem_addr);
   endfunction

   function automatic string exp_str();
      return $sformatf("want v=%b pc=%h ins=%h addr=%0d", e_valid, e_pc, e_instr, e_addr);
   endfunction

   // Driver: apply inputs mid-cycle and derive what the outputs must be now.
   task automatic drive(input logic rdv, input logic [31:0] rpc, input logic rdy);
      @(negedge clk);
      redirect_valid = rdv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
      e_addr = rom_index(m_pc);
      if (exp_q.size() > 0) begin
         e_valid = 1'b1;
         {e_pc, e_instr} = exp_q[0];
      end else if (BYPASS && !rdv) begin
         e_valid = 1'b1;
         e_pc    = m_pc;
         e_instr = rom[rom_index(m_pc)];
      end else begin
         e_valid = 1'b0;
         e_pc    = '0;
         e_instr = '0;
      end
   endtask

   // Advance the model by the clock edge that follows drive().
   task automatic commit();
      logic pop, push;
      pop  = e_valid && out_ready;
      push = !redirect_valid && ((exp_q.size() < DEPTH) || pop);
      if (redirect_valid) begin
         exp_q.delete();
         m_pc = redirect_pc & ~32'h3;
      end else if (pop && exp_q.size() == 0) begin
         m_pc = m_pc + 32'd4;
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (push) begin
            exp_q.push_back({m_pc, rom[rom_index(m_pc)]});
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b0, 32'h0, 32'h0, 6'd0})
         $display("FAIL reset_values: %s want v=0 pc=0 ins=0 addr=0", obs_str());
      else n_pass++;
      @(posedge clk);
      #2 rst = 1'b0;
      exp_q.delete();
      m_pc = 32'h0;
   endtask

   task automatic test_stream();
      int off;
      off = BYPASS ? 0 : 1;
      test_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 32'h0, 1'b1);
         n_checks++;
         if ({out_valid, out_pc, out_instr, imem_addr} !== {e_valid, e_pc, e_instr, e_addr})
            $display("FAIL stream cyc %0d: %s %s", i, obs_str(), exp_str());
         else n_pass++;
         if (i >= off && i < off + 4) begin
            n_checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * (i - off)), init_words[i - off]})
               $display("FAIL stream_word %0d: %s want pc=%h ins=%h", i - off, obs_str(),
                        32'(4 * (i - off)), init_words[i - off]);
            else n_pass++;
         end
         commit();
      end
   endtask

   task automatic test_stall_and_full();
      test_reset();
      for (int i = 0; i < 24; i++) begin
         drive(1'b0, 32'h0, (i >= 10));
         n_checks++;
         if ({out_valid, out_pc, out_instr, imem_addr} !== {e_valid, e_pc, e_instr, e_addr})
            $display("FAIL stall cyc %0d: %s %s", i, obs_str(), exp_str());
         else n_pass++;
         if (i == 9) begin
            n_checks++;
            if (imem_addr !== 6'd4)
               $display("FAIL stall_addr: got addr=%0d want addr=4", imem_addr);
            else n_pass++;
         end
         commit();
      end
   endtask

   task automatic test_redirect();
      test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 1'b0);
         commit();
      end
      for (int i = 0; i < 6; i++) begin
         drive((i == 0), 32'h22, (i >= 1));
         n_checks++;
         if ({out_valid, out_pc, out_instr, imem_addr} !== {e_valid, e_pc, e_instr, e_addr})
            $display("FAIL redirect cyc %0d: %s %s", i, obs_str(), exp_str());
         else n_pass++;
         if (i == (BYPASS ? 1 : 2)) begin
            n_checks++;
            if ({out_valid, out_pc} !== {1'b1, 32'h20})
               $display("FAIL redirect_first: got v=%b pc=%h want v=1 pc=00000020", out_valid, out_pc);
            else n_pass++;
         end
         commit();
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 6; i++) begin
         drive((i == 0), 32'hFFFF_FFFC, 1'b1);
         n_checks++;
         if ({out_valid, out_pc, out_instr, imem_addr} !== {e_valid, e_pc, e_instr, e_addr})
            $display("FAIL wrap cyc %0d: %s %s", i, obs_str(), exp_str());
         else n_pass++;
         commit();
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'h0, 1'b1);
         commit();
      end
      test_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 32'h0, 1'b1);
         n_checks++;
         if ({out_valid, out_pc, out_instr, imem_addr} !== {e_valid, e_pc, e_instr, e_addr})
            $display("FAIL after_reset cyc %0d: %s %s", i, obs_str(), exp_str());
         else n_pass++;
         commit();
      end
   endtask

   task automatic test_random();
      logic        rdv;
      logic [31:0] rpc;
      for (int i = 0; i < 400; i++) begin
         rdv = ($urandom_range(0, 15) == 0);
         rpc = $urandom();
         drive(rdv, rpc, ($urandom_range(0, 9) < 7));
         n_checks++;
         if ({out_valid, out_pc, out_instr, imem_addr} !== {e_valid, e_pc, e_instr, e_addr})
            $display("FAIL random cyc %0d: %s %s", i, obs_str(), exp_str());
         else n_pass++;
         commit();
      end
   endtask

   initial begin
      for (int i = 0; i < SIZE; i++) rom[i] = $urandom();
      init_words[0] = 32'h0000_0013;
      init_words[1] = 32'h0010_0093;
      init_words[2] = 32'h0020_0113;
      init_words[3] = 32'h0030_0193;
      for (int i = 0; i < 4; i++) rom[i] = init_words[i];
      m_pc = 32'h0;

      test_stream();
      test_stall_and_full();
      test_redirect();
      test_wrap();
      test_async_reset();
      test_random();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
